// File: rtl/ifu_fetch_buf_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect input
// and the valid/ready instruction stream toward decode.
interface ifu_fetch_buf_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // Fetch-buffer side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  // Memory / branch unit / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifu_fetch_buf.sv
// Instruction fetch buffer: sequential word fetch from the PC, in-order
// response buffering with per-entry PCs, and wrong-path discard on redirect.
// Requests are credit-limited so outstanding + buffered never exceeds FIFO_DEPTH.
module ifu_fetch_buf #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ifu_fetch_buf_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_WAIT, ST_RUN} state_e;

  state_e        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] sq_rd, sq_wr;

  // Instruction buffer (data + PC) and shadow queue of issued request addresses.
  logic [31:0] data_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] sq_mem   [FIFO_DEPTH];

  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic          buf_valid;
  logic [CW:0]   in_flight;
  logic [CW-1:0] outstanding_nxt;

  // Credit covers both in-flight requests and buffered words, so a push always finds room.
  assign in_flight = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok = in_flight < DEPTH_W;
  assign req_valid = (state == ST_RUN) && !bus.redirect_valid && credit_ok;
  assign req_fire  = req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is spurious and ignored entirely.
  assign rsp_take  = bus.imem_rsp_valid && (outstanding != '0);
  assign push      = rsp_take && (drop == '0) && !bus.redirect_valid;
  assign buf_valid = (count != '0);
  assign pop       = buf_valid && bus.instr_ready;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_take);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = buf_valid;
  assign bus.instr          = buf_valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_pc       = buf_valid ? pc_mem[rd_ptr]   : '0;

  // Control state: FSM, fetch PC, credit/drop counters and queue pointers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT;
      pc          <= PC_RESET;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      sq_rd       <= '0;
      sq_wr       <= '0;
    end else begin
      case (state)
        ST_WAIT: state <= ST_RUN;
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_WAIT;
      endcase

      outstanding <= outstanding_nxt;
      // Shadow queue tracks every request, wrong-path or not, until its response returns.
      if (req_fire) sq_wr <= sq_wr + 1'b1;
      if (rsp_take) sq_rd <= sq_rd + 1'b1;

      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc     <= bus.redirect_pc & ~32'h3;
        drop   <= outstanding_nxt;
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (rsp_take && (drop != '0)) drop <= drop - 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage writes: issued address into the shadow queue, accepted response into the buffer.
  // NOTE: storage arrays carry no reset; only slots marked live by the pointers/count are ever read.
  always_ff @(posedge clk) begin
    if (req_fire) sq_mem[sq_wr] <= pc;
    if (push) begin
      data_mem[wr_ptr] <= bus.imem_rsp_data;
      pc_mem[wr_ptr]   <= sq_mem[sq_rd];
    end
  end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Randomized bench for ifu_fetch_buf with a queue-based reference model,
// plus a second instance checking PC wrap from PC_RESET = 32'hFFFF_FFF8.
module tb_ifu_fetch_buf;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifu_fetch_buf_if bus ();
  ifu_fetch_buf_if bus_b ();

  ifu_fetch_buf #(.PC_RESET(PC_RST), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ifu_fetch_buf #(.PC_RESET(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  // Reference model: requests in flight, buffered words, memory pipeline.
  pend_t       pend_q[$];
  ent_t        fifo_q[$];
  mreq_t       mem_q[$];
  bit          m_running;
  logic [31:0] m_pc;

  int n_checks, n_errors, cyc, req_count;
  bit b_window;
  int k_ready_pct, k_lat_min, k_lat_max, k_iready_pct, k_redir_pct, k_spur_pct;
  bit          force_redir;
  logic [31:0] force_pc;
  bit          arm_t4, t4_fired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  task automatic model_reset();
    pend_q.delete();
    fifo_q.delete();
    mem_q.delete();
    m_running = 1'b0;
    m_pc      = PC_RST;
  endtask

  task automatic quiet_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic do_cycle();
    bit          rv, rdir, rdy, irdy, exp_rv, exp_iv, fire;
    logic [31:0] rd, rpc, exp_i, exp_ipc, b_base, b_addr;
    pend_t       p;
    ent_t        e;
    mreq_t       m;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (mem_q.size() == 0 && $urandom_range(99) < k_spur_pct) begin
      rv = 1'b1;
    end
    rdy  = ($urandom_range(99) < k_ready_pct);
    irdy = ($urandom_range(99) < k_iready_pct);
    rdir = ($urandom_range(99) < k_redir_pct);
    rpc  = $urandom;
    if (force_redir) begin
      rdir = 1'b1;
      rpc = force_pc;
      force_redir = 1'b0;
    end
    if (arm_t4 && rv && irdy && fifo_q.size() > 0 && pend_q.size() > 0 && !pend_q[0].stale) begin
      rdir = 1'b1;
      arm_t4 = 1'b0;
      t4_fired = 1'b1;
    end
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.redirect_valid = rdir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = irdy;
    #1;
    exp_rv  = m_running && !rdir && (pend_q.size() + fifo_q.size() < DEPTH);
    exp_iv  = (fifo_q.size() > 0);
    exp_i   = exp_iv ? fifo_q[0].data : 32'h0;
    exp_ipc = exp_iv ? fifo_q[0].pc : 32'h0;
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    check("req_addr", bus.imem_req_addr, m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(exp_iv));
    check("instr", bus.instr, exp_i);
    check("instr_pc", bus.instr_pc, exp_ipc);
    if (b_window && cyc <= 5) begin
      b_base = 32'hFFFF_FFF8;
      b_addr = b_base + 32'(4 * ((cyc == 0) ? 0 : cyc - 1));
      check("wrap_req_valid", 32'(bus_b.imem_req_valid), 32'((cyc >= 1) && (cyc <= 4)));
      check("wrap_req_addr", bus_b.imem_req_addr, b_addr);
    end
    if (bus.imem_req_valid && rdy) req_count++;
    // Advance the model across the rising edge.
    fire = exp_rv && rdy;
    if (exp_iv && irdy) void'(fifo_q.pop_front());
    if (rv && pend_q.size() > 0) begin
      p = pend_q.pop_front();
      if (!p.stale && !rdir) begin
        e.data = rd;
        e.pc   = p.addr;
        fifo_q.push_back(e);
      end
    end
    if (fire) begin
      p.addr = m_pc;
      p.stale = 1'b0;
      pend_q.push_back(p);
      m.addr = m_pc;
      m.due  = cyc + int'($urandom_range(k_lat_max, k_lat_min));
      mem_q.push_back(m);
      m_pc = m_pc + 32'd4;
    end
    if (rdir) begin
      fifo_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      m_pc = rpc & ~32'h3;
    end
    m_running = 1'b1;
    cyc++;
  endtask

  task automatic set_knobs(input int rdy, input int lmin, input int lmax, input int irdy,
                           input int redir, input int spur);
    k_ready_pct = rdy;  k_lat_min = lmin; k_lat_max = lmax;
    k_iready_pct = irdy; k_redir_pct = redir; k_spur_pct = spur;
  endtask

  initial begin
    int first_iv, start_occ;
    bit found;
    n_checks = 0; n_errors = 0; cyc = 0; req_count = 0;
    force_redir = 1'b0; force_pc = '0; arm_t4 = 1'b0; t4_fired = 1'b0; b_window = 1'b0;
    rst_n = 1'b0;
    quiet_inputs();
    bus_b.imem_req_ready = 1'b1;
    bus_b.imem_rsp_valid = 1'b0;
    bus_b.imem_rsp_data  = '0;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc    = '0;
    bus_b.instr_ready    = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
    b_window = 1'b1;

    // Streaming: ready memory, 1-cycle latency, decode always ready.
    set_knobs(100, 1, 1, 100, 0, 0);
    first_iv = -1;
    for (int i = 0; i < 30; i++) begin
      do_cycle();
      if (bus.instr_valid && first_iv < 0) first_iv = cyc - 1;
    end
    check("first_valid_cycle", 32'(first_iv), 32'd3);
    b_window = 1'b0;

    // Decode stall: buffer fills, requests stop at the credit limit.
    set_knobs(100, 1, 1, 0, 0, 0);
    start_occ = pend_q.size() + fifo_q.size();
    req_count = 0;
    repeat (20) do_cycle();
    check("stall_req_count", 32'(req_count), 32'(DEPTH - start_occ));
    set_knobs(100, 1, 1, 100, 0, 0);
    repeat (20) do_cycle();

    // Redirect with three requests in flight at latency 4.
    set_knobs(100, 4, 4, 100, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      do_cycle();
      found = (pend_q.size() == 3);
    end
    check("three_outstanding_reached", 32'(found), 32'd1);
    force_redir = 1'b1;
    force_pc = 32'h0000_1003;
    do_cycle();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      do_cycle();
      found = bus.instr_valid;
    end
    check("redirect_valid_seen", 32'(found), 32'd1);
    check("redirect_first_pc", bus.instr_pc, 32'h0000_1000);

    // Redirect coinciding with a response and a decode handshake.
    set_knobs(100, 2, 2, 100, 0, 0);
    arm_t4 = 1'b1;
    for (int i = 0; i < 100 && !t4_fired; i++) do_cycle();
    check("coincident_redirect_fired", 32'(t4_fired), 32'd1);
    arm_t4 = 1'b0;
    do_cycle();
    check("valid_after_redirect", 32'(bus.instr_valid), 32'd0);

    // Mixed random traffic.
    set_knobs(70, 1, 5, 60, 3, 5);
    repeat (1500) do_cycle();

    // Asynchronous reset with two requests in flight.
    set_knobs(100, 3, 4, 100, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      do_cycle();
      found = (pend_q.size() == 2);
    end
    check("two_outstanding_reached", 32'(found), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr", bus.imem_req_addr, PC_RST);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    quiet_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
    set_knobs(100, 1, 1, 100, 0, 0);
    repeat (20) do_cycle();
    set_knobs(80, 1, 3, 70, 2, 3);
    repeat (400) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
